// File: rtl/one_port_pipe_mem_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : one_port_pipe_mem_if
// Description : Bus bundle for the single-port pipelined memory: shared
//               address, masked write request and pipelined read return.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
interface one_port_pipe_mem_if #(
  parameter int addressWidth = 5,
  parameter int width        = 8,
  parameter int lanes        = 1
);
  logic [addressWidth-1:0] address;
  logic                    writeEnable;
  logic [lanes-1:0]        writeMask;
  logic [width-1:0]        writeData;
  logic                    readEnable;
  logic [width-1:0]        readData;
  logic                    readValid;

  modport master (
    output address, writeEnable, writeMask, writeData, readEnable,
    input  readData, readValid
  );

  modport slave (
    input  address, writeEnable, writeMask, writeData, readEnable,
    output readData, readValid
  );
endinterface
`default_nettype wire

// File: rtl/one_port_pipe_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : one_port_pipe_mem
// Description : Single-port memory with per-lane write mask, selectable
//               read-during-write behaviour and a fully pipelined read path
//               of 1..4 cycles latency. Contents survive reset.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module one_port_pipe_mem #(
  parameter int addresses   = 32,
  parameter int width       = 8,
  parameter int laneWidth   = 8,
  parameter int readLatency = 1,
  parameter int rdwMode     = 0
) (
  input wire clk,
  input wire rst,
  one_port_pipe_mem_if.slave bus
);

  // Smallest n with 2**n >= value.
  function automatic int clogb2(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) bits = bits + 1;
    return bits;
  endfunction

  localparam int addressWidth = clogb2(addresses);
  localparam int lanes        = (laneWidth > 0) ? (width / laneWidth) : 1;

  if (addresses < 2 || width == 0 || laneWidth <= 0 || (width % laneWidth) != 0 ||
      readLatency < 1 || readLatency > 4 || rdwMode < 0 || rdwMode > 2) begin : g_badParams
    $error("FAIL %m: illegal parameter set for one_port_pipe_mem");
  end

  logic [width-1:0] r_mem [addresses];

  logic             w_inRange;
  logic [width-1:0] w_oldWord;
  logic [width-1:0] w_mergedWord;
  logic             w_issue;
  logic [width-1:0] w_issueData;
  logic             w_lastValid;
  logic [width-1:0] w_lastData;
  logic [width-1:0] r_readData;
  logic             r_readValid;

  // Addresses past the last word never touch the array and read as zero.
  assign w_inRange = 32'(bus.address) < 32'(addresses);
  assign w_oldWord = w_inRange ? r_mem[bus.address] : '0;

  for (genvar l = 0; l < lanes; l++) begin : g_lane
    assign w_mergedWord[l*laneWidth +: laneWidth] = bus.writeMask[l]
        ? bus.writeData[l*laneWidth +: laneWidth]
        : w_oldWord[l*laneWidth +: laneWidth];
  end

  // In write-priority mode a colliding write suppresses the read entirely.
  assign w_issue = !rst && bus.readEnable && (!bus.writeEnable || (rdwMode != 0));

  // Choose the word a newly issued read returns: merged word for write-first.
  always_comb begin
    w_issueData = w_oldWord;
    if (bus.writeEnable && (rdwMode == 1)) begin
      w_issueData = w_inRange ? w_mergedWord : '0;
    end
  end

  // Masked write of the array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && bus.writeEnable && w_inRange) begin
      r_mem[bus.address] <= w_mergedWord;
    end
  end

  if (readLatency == 1) begin : g_lat1
    assign w_lastValid = w_issue;
    assign w_lastData  = w_issueData;
  end else begin : g_latN
    logic             r_dlyValid [readLatency-1];
    logic [width-1:0] r_dlyData  [readLatency-1];

    // Valid bits of the delay line; reset drops every read in flight.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < readLatency - 1; k++) r_dlyValid[k] <= 1'b0;
      end else begin
        r_dlyValid[0] <= w_issue;
        for (int k = 1; k < readLatency - 1; k++) r_dlyValid[k] <= r_dlyValid[k-1];
      end
    end

    // Data of the delay line travels alongside its valid bit.
    always_ff @(posedge clk) begin
      r_dlyData[0] <= w_issueData;
      for (int k = 1; k < readLatency - 1; k++) r_dlyData[k] <= r_dlyData[k-1];
    end

    assign w_lastValid = r_dlyValid[readLatency-2];
    assign w_lastData  = r_dlyData[readLatency-2];
  end

  // Output register: pulse valid, hold data between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_readValid <= 1'b0;
      r_readData  <= '0;
    end else begin
      r_readValid <= w_lastValid;
      if (w_lastValid) r_readData <= w_lastData;
    end
  end

  assign bus.readData  = r_readData;
  assign bus.readValid = r_readValid;

endmodule
`default_nettype wire

// File: doc/one_port_pipe_mem.md
ONE_PORT_PIPE_MEM -- requirements
Module: one_port_pipe_mem

Interface
REQ-001 SHALL have parameter addresses, default 32: number of words.
REQ-002 SHALL have parameter width, default 8: bits per word.
REQ-003 SHALL have parameter laneWidth, default 8: bits per write-mask lane; width SHALL be a multiple of laneWidth.
REQ-004 SHALL have parameter readLatency, default 1, legal 1..4: cycles from read issue to readValid.
REQ-005 SHALL have parameter rdwMode, default 0: 0 = write-priority (no read), 1 = write-first, 2 = read-first.
REQ-006 SHALL have localparam addressWidth = clogb2(addresses) and localparam lanes = width/laneWidth; neither is user-settable.
REQ-007 SHALL have port clk, input, 1: sole clock, all logic on rising edge.
REQ-008 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-009 SHALL have port address, input, addressWidth: word address for read and write.
REQ-010 SHALL have port writeEnable, input, 1: write request this cycle.
REQ-011 SHALL have port writeMask, input, lanes: per-lane write enable, bit i covers bits [i*laneWidth +: laneWidth].
REQ-012 SHALL have port writeData, input, width: write word.
REQ-013 SHALL have port readEnable, input, 1: read request this cycle.
REQ-014 SHALL have port readData, output, width: registered read word.
REQ-015 SHALL have port readValid, output, 1: one-cycle pulse, readData updated this cycle.

Function
REQ-016 SHALL, on a rising edge with writeEnable=1 and rst=0, update only the lanes of mem[address] whose writeMask bit is 1; other lanes keep their value.
REQ-017 SHALL treat writeMask=0 with writeEnable=1 as a no-op write (no lane changes; rdwMode still governs any read).
REQ-018 SHALL issue a read on a rising edge with readEnable=1, writeEnable=0, rst=0.
REQ-019 SHALL, when readEnable and writeEnable are both 1: rdwMode 0 issue no read; rdwMode 1 issue a read returning the post-write merged word; rdwMode 2 issue a read returning the pre-write word.
REQ-020 SHALL present the data of a read issued at edge N on readData, with readValid=1, in the cycle after edge N+readLatency-1 (readLatency=1: valid the cycle after the issuing edge).
REQ-021 SHALL accept one read per cycle back-to-back; the read pipeline SHALL be fully pipelined with no stalls and preserve issue order.
REQ-022 SHALL hold readData at its last valid value while readValid=0.
REQ-023 SHALL ignore writes with address >= addresses; a read to such an address SHALL return all-zero data with a normal readValid pulse.
REQ-024 SHALL make a write at edge N visible to any read issued at edge N+1 or later regardless of readLatency.
REQ-025 SHALL, in simulation, print a FAIL message with %m and $stop at time 0 if addresses<2, width=0, width not a multiple of laneWidth, readLatency outside 1..4, or rdwMode outside 0..2.

Reset
REQ-026 SHALL, on a rising edge with rst=1, set readData to 0, readValid to 0, and clear every read-pipeline valid stage.
REQ-027 SHALL ignore writeEnable and readEnable on any edge where rst=1.
REQ-028 SHALL retain memory contents through reset (array not cleared).
REQ-029 SHALL discard reads in flight when rst asserts; no readValid SHALL follow for them after rst deasserts.

Verification
REQ-030 Defaults; write 0xA5 to addr 3, read addr 3 next cycle -> readValid=1 one cycle after read edge, readData=0xA5.
REQ-031 width=32, laneWidth=8; write 0x11223344 to addr 5, then write 0xAABBCCDD mask 4'b0101, read -> 0x11BB33DD.
REQ-032 readLatency=3; reads to addr 0,1,2 on consecutive edges holding 0x10,0x20,0x30 -> readValid high 3 consecutive cycles, data 0x10,0x20,0x30, first valid 3 cycles after first issue.
REQ-033 addr 7 holds 0x01; same-cycle write 0x02 + read addr 7 -> rdwMode 0: no readValid; mode 1: 0x02; mode 2: 0x01; mem[7]=0x02 in all modes.
REQ-034 readLatency=4; issue read, assert rst 2 cycles later for 1 cycle -> readData=0, no readValid ever for that read; earlier-written data still readable after reset.
REQ-035 addresses=20; write 0xFF to addr 25, read addr 25 -> readValid=1, readData=0; mem[25 mod 32 aliasing] unaffected (addr 25-20 etc. unchanged).
